bit_entry_conditioner: RTL and testbench

- Upstream front end for the serial bit-entry sequence detector.
- Converts the two raw push-buttons (P0 enters a 0, P1 enters a 1) into clean, single-cycle, mclk-domain bit strobes.
- Replaces the separate divided-clock plus debounce path: everything runs on mclk with an internal sample-tick enable, so the detector can run on mclk with a clock enable instead of a derived clock.
- Also flags illegal simultaneous presses and counts accepted bits for display/VIO.

---
 rtl/bit_entry_conditioner_pkg.sv | 24 ++
 rtl/bit_entry_conditioner_sync2.sv | 28 ++
 rtl/bit_entry_conditioner.sv | 207 ++++++++++++++++++++
 tb/tb_bit_entry_conditioner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_entry_conditioner_pkg.sv
// Shared definitions for the bit-entry front end.
//   state_e           : conditioner FSM states
//   PAT_*             : synchronized button pattern encoding {P1, P0}
//   DEF_TICK_DIV      : default mclk cycles per debounce sample tick
//   DEF_STABLE_TICKS  : default stable ticks required for press/release
package bit_entry_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_HELD      = 3'd2,
    ST_DEB_REL   = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_e;

  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_ZERO = 2'b01;
  localparam logic [1:0] PAT_ONE  = 2'b10;
  localparam logic [1:0] PAT_BOTH = 2'b11;

  localparam int unsigned DEF_TICK_DIV     = 262144;
  localparam int unsigned DEF_STABLE_TICKS = 4;

endpackage

// File: rtl/bit_entry_conditioner_sync2.sv
// Two-flop synchronizer for one asynchronous input.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (clears both flops)
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i edges of latency
module bit_entry_conditioner_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bit_entry_conditioner.sv
// Push-button front end for the serial bit-entry detector. Synchronizes the
// two raw buttons, debounces them on an internal sample tick and produces
// clean single-cycle mclk-domain strobes.
//   mclk      : system clock, rising edge
//   Reset     : asynchronous active-low reset
//   P0 / P1   : raw async active-high buttons (enter bit 0 / bit 1)
//   bit_valid : one-cycle strobe, a debounced bit was accepted
//   bit_val   : value of the last accepted bit (held)
//   conflict  : one-cycle strobe, both buttons seen pressed
//   busy      : FSM not in IDLE
//   bit_count : accepted-bit counter, wraps silently
module bit_entry_conditioner
  import bit_entry_conditioner_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             mclk,
  input  logic             Reset,
  input  logic             P0,
  input  logic             P1,
  output logic             bit_valid,
  output logic             bit_val,
  output logic             conflict,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned      TCW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [TCW-1:0]   TC_ONE    = TCW'(1);
  localparam logic [3:0]       STB_MAX   = 4'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Synchronizers
  logic s0;
  logic s1;

  bit_entry_conditioner_sync2 u_sync_p0 (
    .clk_i  (mclk),
    .rst_ni (Reset),
    .d_i    (P0),
    .q_o    (s0)
  );

  bit_entry_conditioner_sync2 u_sync_p1 (
    .clk_i  (mclk),
    .rst_ni (Reset),
    .d_i    (P1),
    .q_o    (s1)
  );

  // Sample tick generator
  logic [TCW-1:0] tick_cnt_q;
  logic           tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge mclk or negedge Reset) begin
    if (!Reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TC_ONE;
    end
  end

  // Debounce FSM
  state_e     state_q, state_d;
  logic       cand_q, cand_d;     // candidate bit value while debouncing a press
  logic [3:0] stb_q, stb_d;
  logic [3:0] stb_inc;
  logic [1:0] pat;
  logic       pat_is_one;
  logic       accept;
  logic       accept_val;
  logic       conf;

  assign pat        = {s1, s0};
  assign pat_is_one = (pat == PAT_ONE);
  assign stb_inc    = stb_q + 4'd1;

  always_ff @(posedge mclk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cand_q  <= 1'b0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    stb_d      = stb_q;
    accept     = 1'b0;
    accept_val = cand_q;
    conf       = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pat == PAT_ZERO || pat == PAT_ONE) begin
            cand_d = pat_is_one;
            stb_d  = 4'd1;
            // A single stable tick is enough: accept without visiting DEB_PRESS.
            if (STB_MAX == 4'd1) begin
              state_d    = ST_HELD;
              accept     = 1'b1;
              accept_val = pat_is_one;
            end else begin
              state_d = ST_DEB_PRESS;
            end
          end else if (pat == PAT_BOTH) begin
            state_d = ST_LOCKOUT;
            conf    = 1'b1;
          end
        end

        ST_DEB_PRESS: begin
          if (pat == PAT_NONE) begin
            state_d = ST_IDLE;
          end else if (pat == PAT_BOTH) begin
            state_d = ST_LOCKOUT;
            conf    = 1'b1;
          end else if (pat_is_one == cand_q) begin
            stb_d = stb_inc;
            if (stb_inc >= STB_MAX) begin
              state_d    = ST_HELD;
              accept     = 1'b1;
              accept_val = cand_q;
            end
          end else begin
            cand_d = pat_is_one;
            stb_d  = 4'd1;
          end
        end

        ST_HELD: begin
          if (pat == PAT_NONE) begin
            stb_d   = 4'd1;
            state_d = (STB_MAX == 4'd1) ? ST_IDLE : ST_DEB_REL;
          end else if (pat == PAT_BOTH) begin
            state_d = ST_LOCKOUT;
            conf    = 1'b1;
          end
        end

        ST_DEB_REL: begin
          if (pat == PAT_NONE) begin
            stb_d = stb_inc;
            if (stb_inc >= STB_MAX) begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_HELD;
          end
        end

        ST_LOCKOUT: begin
          if (pat == PAT_NONE) begin
            stb_d   = 4'd1;
            state_d = (STB_MAX == 4'd1) ? ST_IDLE : ST_DEB_REL;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs
  logic             bit_valid_q;
  logic             bit_val_q;
  logic             conflict_q;
  logic [CNT_W-1:0] bit_count_q;

  always_ff @(posedge mclk or negedge Reset) begin
    if (!Reset) begin
      bit_valid_q <= 1'b0;
      bit_val_q   <= 1'b0;
      conflict_q  <= 1'b0;
      bit_count_q <= '0;
    end else begin
      bit_valid_q <= accept;
      conflict_q  <= conf;
      if (accept) begin
        bit_val_q   <= accept_val;
        bit_count_q <= bit_count_q + CNT_ONE;
      end
    end
  end

  assign bit_valid = bit_valid_q;
  assign bit_val   = bit_val_q;
  assign conflict  = conflict_q;
  assign bit_count = bit_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bit_entry_conditioner.sv
module tb_bit_entry_conditioner;

  logic       mclk = 1'b0;
  logic       Reset;
  logic       P0;
  logic       P1;
  logic       bit_valid;
  logic       bit_val;
  logic       conflict;
  logic       busy;
  logic [7:0] bit_count;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int bv_cnt = 0;
  int cf_cnt = 0;
  int bv_cyc = -1;
  bit overlap = 1'b0;
  bit wide = 1'b0;
  logic bv_prev = 1'b0;
  logic cf_prev = 1'b0;

  bit_entry_conditioner #(
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .CNT_W        (8)
  ) dut (
    .mclk      (mclk),
    .Reset     (Reset),
    .P0        (P0),
    .P1        (P1),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .conflict  (conflict),
    .busy      (busy),
    .bit_count (bit_count)
  );

  always #5 mclk = ~mclk;

  // Edge index since reset release; the DUT tick counter equals cyc mod 4.
  always @(posedge mclk or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge mclk) begin
    if (bit_valid) begin
      bv_cnt = bv_cnt + 1;
      bv_cyc = cyc;
    end
    if (conflict) cf_cnt = cf_cnt + 1;
    if (bit_valid && conflict) overlap = 1'b1;
    if ((bit_valid && bv_prev) || (conflict && cf_prev)) wide = 1'b1;
    bv_prev = bit_valid;
    cf_prev = conflict;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_val({pfx, "_bit_valid"}, 32'(bit_valid), 0);
    check_val({pfx, "_bit_val"},   32'(bit_val),   0);
    check_val({pfx, "_conflict"},  32'(conflict),  0);
    check_val({pfx, "_busy"},      32'(busy),      0);
    check_val({pfx, "_bit_count"}, 32'(bit_count), 0);
  endtask

  task automatic press(input logic b);
    if (b) P1 = 1'b1;
    else   P0 = 1'b1;
    step(24);
    P0 = 1'b0;
    P1 = 1'b0;
    step(24);
  endtask

  int base;
  int cbase;
  int p;
  int exp_e;

  initial begin
    Reset = 1'b0;
    P0    = 1'b0;
    P1    = 1'b0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check_zero_outputs("rst");
    @(posedge mclk);
    #1 Reset = 1'b1;
    step(5);

    // Clean P1 press: accept lands 8 edges after the first tick edge that
    // sees the synchronized press (tick edges are multiples of 4).
    base  = bv_cnt;
    p     = cyc;
    exp_e = ((p + 6) / 4) * 4 + 8;
    P1    = 1'b1;
    step(40);
    check_val("t1_busy_held", 32'(busy), 1);
    P1 = 1'b0;
    step(30);
    check_val("t1_count",   bv_cnt - base, 1);
    check_val("t1_latency", bv_cyc, exp_e);
    check_val("t1_val",     32'(bit_val), 1);
    check_val("t1_bcnt",    32'(bit_count), 1);
    check_val("t1_busy",    32'(busy), 0);

    // P0 bouncing with period 6 never gives 3 consecutive pressed samples.
    base = bv_cnt;
    for (int i = 0; i < 20; i++) begin
      P0 = (((i / 3) % 2) == 0);
      step(1);
    end
    check_val("t2_bounce", bv_cnt - base, 0);
    P0 = 1'b1;
    step(30);
    check_val("t2_count", bv_cnt - base, 1);
    check_val("t2_val",   32'(bit_val), 0);
    check_val("t2_bcnt",  32'(bit_count), 2);
    P0 = 1'b0;
    step(30);
    check_val("t2_busy", 32'(busy), 0);

    // Short P0 pulse
    base = bv_cnt;
    P0 = 1'b1;
    step(5);
    P0 = 1'b0;
    step(30);
    check_val("t3_count", bv_cnt - base, 0);
    check_val("t3_bcnt",  32'(bit_count), 2);
    check_val("t3_busy",  32'(busy), 0);

    // P0 accepted, then P1 joins -> conflict
    base  = bv_cnt;
    cbase = cf_cnt;
    P0 = 1'b1;
    step(30);
    check_val("t4_bv",  bv_cnt - base, 1);
    check_val("t4_val", 32'(bit_val), 0);
    P1 = 1'b1;
    step(20);
    check_val("t4_conf",     cf_cnt - cbase, 1);
    check_val("t4_bv_after", bv_cnt - base, 1);
    check_val("t4_bcnt",     32'(bit_count), 3);
    check_val("t4_busy_lk",  32'(busy), 1);
    P0 = 1'b0;
    P1 = 1'b0;
    step(30);
    check_val("t4_rel_bv",   bv_cnt - base, 1);
    check_val("t4_rel_conf", cf_cnt - cbase, 1);
    check_val("t4_rel_busy", 32'(busy), 0);
    P1 = 1'b1;
    step(30);
    P1 = 1'b0;
    step(30);
    check_val("t4_p1_bv",   bv_cnt - base, 2);
    check_val("t4_p1_val",  32'(bit_val), 1);
    check_val("t4_p1_bcnt", 32'(bit_count), 4);

    // Counter wrap
    base = bv_cnt;
    for (int i = 0; i < 251; i++) press(i[0]);
    check_val("t5_bv_pre",   bv_cnt - base, 251);
    check_val("t5_bcnt_max", 32'(bit_count), 255);
    press(1'b1);
    check_val("t5_bv_wrap",   bv_cnt - base, 252);
    check_val("t5_bcnt_wrap", 32'(bit_count), 0);
    check_val("t5_val",       32'(bit_val), 1);

    // Reset during DEB_PRESS with P1 held
    base = bv_cnt;
    P1 = 1'b1;
    for (int k = 0; k < 40 && !busy; k++) step(1);
    check_val("t6_busy", 32'(busy), 1);
    step(2);
    Reset = 1'b0;
    #1;
    check_zero_outputs("t6_rst");
    check_val("t6_nostrobe", bv_cnt - base, 0);
    step(5);
    Reset = 1'b1;
    step(30);
    check_val("t6_count",   bv_cnt - base, 1);
    check_val("t6_latency", bv_cyc, 12);
    check_val("t6_val",     32'(bit_val), 1);
    check_val("t6_bcnt",    32'(bit_count), 1);
    P1 = 1'b0;
    step(30);
    check_val("t6_busy_end", 32'(busy), 0);

    check_val("strobe_overlap", 32'(overlap), 0);
    check_val("strobe_width",   32'(wide), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
